// File: rtl/user_keys_debounce.sv
// Debounced user-key driver for the IO bridge: per-key synchroniser and debounce counter,
// LEVEL / sticky PRESS / CTRL registers and a registered level interrupt.
module user_keys_debounce #(
    parameter int N_KEYS     = 8,
    parameter int DB_CYCLES  = 1000000,
    parameter int DB_W       = 20,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    input  logic [N_KEYS-1:0] user_key,
    output logic              irq
);

    localparam logic [N_KEYS-1:0] IDLE_LVL = {N_KEYS{ACTIVE_LOW != 0}};
    localparam logic [DB_W-1:0]   CNT_MAX  = DB_W'(DB_CYCLES - 1);

    logic [N_KEYS-1:0] sync_p0, sync_p1;
    logic [N_KEYS-1:0] key_s;
    logic [N_KEYS-1:0] level, level_nxt;
    logic [N_KEYS-1:0] press, press_nxt, press_clr, rise;
    logic [N_KEYS-1:0] ctrl_mask;
    logic              ctrl_en;
    logic [DB_W-1:0]   cnt     [N_KEYS];
    logic [DB_W-1:0]   cnt_nxt [N_KEYS];
    logic              wr_press, wr_ctrl;
    logic [31:0]       rd_data;
    logic              unused_bus;

    assign unused_bus = ^{Addr, Din};

    assign wr_press  = WE && (Addr[3:2] == 2'd1);
    assign wr_ctrl   = WE && (Addr[3:2] == 2'd2);
    assign press_clr = wr_press ? Din[N_KEYS-1:0] : '0;

    // stage p1 -> debounce: normalise polarity so 1 always means pressed
    assign key_s = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

    always_comb begin
        level_nxt = level;
        rise      = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_nxt[i] = '0;
            if (key_s[i] != level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = key_s[i];
                    rise[i]      = key_s[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press landing on the same edge as a W1C clear must survive
    assign press_nxt = (press & ~press_clr) | rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= IDLE_LVL;
            sync_p1   <= IDLE_LVL;
            level     <= '0;
            press     <= '0;
            ctrl_mask <= '0;
            ctrl_en   <= 1'b0;
            irq       <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= user_key;
            sync_p1 <= sync_p0;
            level   <= level_nxt;
            press   <= press_nxt;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (wr_ctrl) begin
                ctrl_mask <= Din[N_KEYS-1:0];
                ctrl_en   <= Din[31];
            end
            irq <= ctrl_en & |(press & ctrl_mask);
        end
    end

    always_comb begin
        rd_data = '0;
        case (Addr[3:2])
            2'd0: rd_data[N_KEYS-1:0] = level;
            2'd1: rd_data[N_KEYS-1:0] = press;
            2'd2: begin
                rd_data[N_KEYS-1:0] = ctrl_mask;
                rd_data[31]         = ctrl_en;
            end
            default: rd_data = '0;
        endcase
    end

    assign Dout = rd_data;

endmodule
